// File: rtl/ifu_pkg.sv
// Shared types and constants for the ifu_fetch instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    IDLE = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues one imem request at a
// time (req/gnt + rvalid), holds the returned word for decode (valid/ready)
// and waits for the writeback redirect (dnpc) before the next fetch.
// Optional build macro IFU_MISALIGN_CHECK_EN: a PC with nonzero low bits
// is not fetched; a nop is presented with fetch_err set instead.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] snpc,
  output logic              valid,
  input  logic              ready,
  output logic              fetch_err
);

  ifu_state_e        state, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              redir_pend, redir_pend_d;
  logic [ADDR_W-1:0] redir_pc, redir_pc_d;

`ifdef IFU_MISALIGN_CHECK_EN
  logic misaligned;
  logic fetch_err_q;
  assign misaligned = (pc_q[1:0] != 2'b00);
`endif

  // Next-state and holding-register update logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch; blocking '=' is correct in
    // combinational blocks.
    state_d      = state;
    pc_d         = pc_q;
    inst_d       = inst_q;
    redir_pend_d = redir_pend;
    redir_pc_d   = redir_pc;

    case (state)
      BOOT: state_d = REQ;
      REQ: begin
`ifdef IFU_MISALIGN_CHECK_EN
        if (misaligned) begin
          state_d = HOLD;
          inst_d  = IFU_NOP;
        end else
`endif
        if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        // rvalid is only meaningful here; any other state ignores it.
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready) state_d = IDLE;
      end
      IDLE: begin
        // A live redirect is newer than anything pended earlier.
        if (redirect_valid) begin
          pc_d         = redirect_pc;
          redir_pend_d = 1'b0;
          state_d      = REQ;
        end else if (redir_pend) begin
          pc_d         = redir_pc;
          redir_pend_d = 1'b0;
          state_d      = REQ;
        end
      end
      default: state_d = BOOT;
    endcase

    // Redirects arriving outside IDLE (including on the HOLD handshake)
    // are kept until IDLE consumes them; the latest one wins.
    if (state != IDLE && redirect_valid) begin
      redir_pend_d = 1'b1;
      redir_pc_d   = redirect_pc;
    end
  end

  // State and holding registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register, including the data-only inst and redir_pc,
    // takes a reset value so the unit leaves reset fully defined; state is
    // updated with non-blocking '<=' so all registers see pre-edge values.
    if (rst) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      redir_pend <= 1'b0;
      redir_pc   <= '0;
    end else begin
      state      <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      redir_pend <= redir_pend_d;
      redir_pc   <= redir_pc_d;
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  // fetch_err is raised with the nop substitution and dropped on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_err_q <= 1'b0;
    end else if (state == REQ && misaligned) begin
      fetch_err_q <= 1'b1;
    end else if (state == HOLD && ready) begin
      fetch_err_q <= 1'b0;
    end
  end

  assign imem_req  = (state == REQ) && !misaligned;
  assign fetch_err = fetch_err_q;
`else
  assign imem_req  = (state == REQ);
  assign fetch_err = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign snpc      = pc_q + ADDR_W'(4);
  assign inst      = inst_q;
  assign valid     = (state == HOLD);

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a cycle vector table, hand-written
// corner sequences, then randomized traffic against a transaction model.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] snpc;
  logic        valid;
  logic        ready = 1'b0;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst           (inst),
    .pc             (pc),
    .snpc           (snpc),
    .valid          (valid),
    .ready          (ready),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic gnt,
                       input logic rvl, input logic [31:0] rdata, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_gnt       = gnt;
    imem_rvalid    = rvl;
    imem_rdata     = rdata;
    ready          = rdy;
  endtask

  // Memory contents seen by the random phase: any fixed function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic gnt,
                              input logic rvl, input logic [31:0] rdata, input logic rdy,
                              input logic e_req, input logic e_valid,
                              input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.gnt = gnt; v.rvalid = rvl; v.rdata = rdata; v.rdy = rdy;
    v.e_req = e_req; v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  localparam int NV = 22;
  vec_t vec [NV];

  // Random-phase model state
  logic [31:0] exp_addr, out_addr, next_pc;
  logic        out_busy, armed;
  int          resp_cnt, redir_cnt, n_done, stall;
  logic        s_req, s_valid, s_ferr;
  logic [31:0] s_addr, s_pc, s_inst, s_snpc;

  initial begin
    // Row = inputs applied during one cycle, and the outputs expected then.
    vec[0]  = mk(0, 32'h0,         1, 0, 32'h0,         0, 0, 0, 32'h8000_0000, 32'h0);
    vec[1]  = mk(0, 32'h0,         1, 0, 32'h0,         0, 1, 0, 32'h8000_0000, 32'h0);
    vec[2]  = mk(0, 32'h0,         0, 1, 32'h0010_0093, 0, 0, 0, 32'h8000_0000, 32'h0);
    vec[3]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 1, 32'h8000_0000, 32'h0010_0093);
    vec[4]  = mk(0, 32'h0,         0, 1, 32'h1111_1111, 0, 0, 1, 32'h8000_0000, 32'h0010_0093);
    vec[5]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 1, 32'h8000_0000, 32'h0010_0093);
    vec[6]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 1, 32'h8000_0000, 32'h0010_0093);
    vec[7]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 1, 32'h8000_0000, 32'h0010_0093);
    vec[8]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 0, 1, 32'h8000_0000, 32'h0010_0093);
    vec[9]  = mk(1, 32'h8000_0010, 0, 0, 32'h0,         0, 0, 0, 32'h8000_0000, 32'h0);
    vec[10] = mk(0, 32'h0,         0, 1, 32'h2222_2222, 0, 1, 0, 32'h8000_0010, 32'h0);
    vec[11] = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 0, 32'h8000_0010, 32'h0);
    vec[12] = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 0, 32'h8000_0010, 32'h0);
    vec[13] = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 0, 32'h8000_0010, 32'h0);
    vec[14] = mk(0, 32'h0,         1, 0, 32'h0,         0, 1, 0, 32'h8000_0010, 32'h0);
    vec[15] = mk(1, 32'h8000_0040, 0, 0, 32'h0,         0, 0, 0, 32'h8000_0010, 32'h0);
    vec[16] = mk(1, 32'h8000_0100, 0, 0, 32'h0,         0, 0, 0, 32'h8000_0010, 32'h0);
    vec[17] = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h8000_0010, 32'h0);
    vec[18] = mk(0, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'h8000_0010, 32'h0);
    vec[19] = mk(0, 32'h0,         0, 0, 32'h0,         1, 0, 1, 32'h8000_0010, 32'hDEAD_BEEF);
    vec[20] = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h8000_0010, 32'h0);
    vec[21] = mk(0, 32'h0,         1, 0, 32'h0,         0, 1, 0, 32'h8000_0100, 32'h0);

    // ---------------- reset and vector table ----------------
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset.valid", valid, 0);
    check("reset.req", imem_req, 0);
    check("reset.pc", pc, 32'h8000_0000);
    check("reset.inst", inst, 32'h0);
    check("reset.fetch_err", fetch_err, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].rv, vec[i].rpc, vec[i].gnt, vec[i].rvalid, vec[i].rdata, vec[i].rdy);
      #1;
      check($sformatf("vec%0d.req", i), imem_req, vec[i].e_req);
      check($sformatf("vec%0d.valid", i), valid, vec[i].e_valid);
      check($sformatf("vec%0d.pc", i), pc, vec[i].e_pc);
      check($sformatf("vec%0d.addr", i), imem_addr, vec[i].e_pc);
      if (vec[i].e_valid) begin
        check($sformatf("vec%0d.inst", i), inst, vec[i].e_inst);
        check($sformatf("vec%0d.snpc", i), snpc, vec[i].e_pc + 32'd4);
      end
      @(negedge clk);
    end

    // ---------------- async reset while in WAIT ----------------
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    #1;
    check("areset.pre_req", imem_req, 0);
    check("areset.pre_pc", pc, 32'h8000_0100);
    rst = 1'b1;
    #1;
    check("areset.req", imem_req, 0);
    check("areset.valid", valid, 0);
    check("areset.pc", pc, 32'h8000_0000);
    drive(0, 32'h0, 0, 1, 32'hBAD0_BAD0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("areset.boot_req", imem_req, 0);
    check("areset.boot_valid", valid, 0);
    @(negedge clk); #1;
    check("areset.refetch_req", imem_req, 1);
    check("areset.refetch_addr", imem_addr, 32'h8000_0000);
    drive(0, 32'h0, 1, 0, 32'h0, 0);
    @(negedge clk); #1;
    check("areset.wait_req", imem_req, 0);
    drive(0, 32'h0, 0, 1, 32'h0020_0113, 0);
    @(negedge clk); #1;
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    check("areset.valid_hold", valid, 1);
    check("areset.inst", inst, 32'h0020_0113);
    check("areset.hold_pc", pc, 32'h8000_0000);

    // ---------------- redirect on handshake, snpc wrap ----------------
    drive(1, 32'hFFFF_FFFC, 0, 0, 32'h0, 1);
    @(negedge clk); #1;
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    check("hsredir.idle_valid", valid, 0);
    check("hsredir.idle_req", imem_req, 0);
    @(negedge clk); #1;
    check("hsredir.req", imem_req, 1);
    check("hsredir.addr", imem_addr, 32'hFFFF_FFFC);
    drive(0, 32'h0, 1, 0, 32'h0, 0);
    @(negedge clk); #1;
    drive(0, 32'h0, 0, 1, 32'h1357_2468, 0);
    @(negedge clk); #1;
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    check("wrap.valid", valid, 1);
    check("wrap.pc", pc, 32'hFFFF_FFFC);
    check("wrap.snpc", snpc, 32'h0000_0000);
    check("wrap.inst", inst, 32'h1357_2468);
    drive(0, 32'h0, 0, 0, 32'h0, 1);
    @(negedge clk); #1;

    // ---------------- misaligned redirect ----------------
    drive(1, 32'h8000_0102, 0, 0, 32'h0, 0);
    @(negedge clk); #1;
    drive(0, 32'h0, 0, 0, 32'h0, 0);
`ifdef IFU_MISALIGN_CHECK_EN
    check("misalign.no_req", imem_req, 0);
    check("misalign.pc", pc, 32'h8000_0102);
    @(negedge clk); #1;
    check("misalign.valid", valid, 1);
    check("misalign.fetch_err", fetch_err, 1);
    check("misalign.inst", inst, 32'h0000_0013);
    drive(0, 32'h0, 0, 0, 32'h0, 1);
    @(negedge clk); #1;
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    check("misalign.err_clear", fetch_err, 0);
    check("misalign.valid_clear", valid, 0);
`else
    check("misalign.req", imem_req, 1);
    check("misalign.addr", imem_addr, 32'h8000_0102);
    check("misalign.fetch_err_req", fetch_err, 0);
    drive(0, 32'h0, 1, 0, 32'h0, 0);
    @(negedge clk); #1;
    drive(0, 32'h0, 0, 1, 32'h00A0_0513, 0);
    @(negedge clk); #1;
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    check("misalign.valid", valid, 1);
    check("misalign.fetch_err", fetch_err, 0);
    check("misalign.inst", inst, 32'h00A0_0513);
    drive(0, 32'h0, 0, 0, 32'h0, 1);
    @(negedge clk); #1;
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    check("misalign.valid_clear", valid, 0);
`endif

    // ---------------- randomized traffic vs transaction model ----------------
    // Model: each fetch reads mem_word(addr) at the address of the last
    // redirect issued after the previous retirement (RESET_PC first).
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_addr = 32'h8000_0000;
    out_busy = 1'b0; armed = 1'b0; out_addr = '0; next_pc = '0;
    resp_cnt = 0; redir_cnt = 0; n_done = 0; stall = 0;
    for (int cyc = 0; cyc < 4000 && n_done < 150; cyc++) begin
      #1;
      s_req = imem_req; s_valid = valid; s_ferr = fetch_err;
      s_addr = imem_addr; s_pc = pc; s_inst = inst; s_snpc = snpc;

      // memory response side
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (out_busy) begin
        check("rnd.no_req_while_busy", s_req, 0);
        if (resp_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(out_addr);
          out_busy    = 1'b0;
        end else begin
          resp_cnt--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        imem_rvalid = 1'b1;  // stray beat, must be ignored
      end

      // memory grant side
      imem_gnt = s_req && ($urandom_range(0, 1) == 1);
      if (imem_gnt) begin
        check("rnd.fetch_addr", s_addr, exp_addr);
        out_busy = 1'b1;
        out_addr = s_addr;
        resp_cnt = $urandom_range(0, 3);
      end

      // decode side
      ready = ($urandom_range(0, 3) != 0);
      if (s_valid) begin
        check("rnd.pc", s_pc, exp_addr);
        check("rnd.inst", s_inst, mem_word(exp_addr));
        check("rnd.snpc", s_snpc, exp_addr + 32'd4);
        check("rnd.fetch_err", s_ferr, 0);
        if (ready) begin
          n_done++;
          stall     = 0;
          armed     = 1'b1;
          redir_cnt = $urandom_range(0, 3);
          next_pc   = $urandom & 32'hFFFF_FFFC;
        end
      end

      // writeback side: one redirect per retirement, 0..3 cycles later
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      if (armed) begin
        if (redir_cnt == 0) begin
          redirect_valid = 1'b1;
          redirect_pc    = next_pc;
          exp_addr       = next_pc;
          armed          = 1'b0;
        end else begin
          redir_cnt--;
        end
      end

      stall++;
      if (stall > 200) begin
        check("rnd.progress_timeout", 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
    end
    check("rnd.retired_enough", (n_done >= 150) ? 32'd1 : 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
